// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: Moore-style main control FSM for a multicycle MIPS-like datapath.
// Ports:
//   clk, reset (async, active-low)
//   opCode[5:0]  - instruction[31:26], used in DECODE and MEMADR
//   memReady     - memory handshake, sampled only in FETCH / MEMRD / MEMWR
//   pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
//   regWrite, regDst, aluSrcA - datapath enables and selects
//   aluOp[1:0], aluSrcB[1:0], pcSource[1:0] - datapath mux / ALU controls
//   illegalOp    - pulse in DECODE on an undecodable opcode
//   state[3:0]   - current state code (debug)
module mc_main_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       irWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       aluSrcA,
  output logic [1:0] aluOp,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSource,
  output logic       illegalOp,
  output logic [3:0] state
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  state_e state_q, state_d;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and Moore outputs (memReady/opCode terms where the state needs them).
  always_comb begin
    state_d     = S_FETCH;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    irWrite     = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    aluSrcA     = 1'b0;
    aluOp       = 2'b00;
    aluSrcB     = 2'b00;
    pcSource    = 2'b00;
    illegalOp   = 1'b0;

    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
        state_d = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (opCode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegalOp = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        state_d = memReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        state_d  = memReady ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs are forced quiet for the whole time reset is held, not only at the edge.
    if (!reset) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      memToReg    = 1'b0;
      irWrite     = 1'b0;
      regWrite    = 1'b0;
      regDst      = 1'b0;
      aluSrcA     = 1'b0;
      aluOp       = 2'b00;
      aluSrcB     = 2'b00;
      pcSource    = 2'b00;
      illegalOp   = 1'b0;
    end
  end

  assign state = 4'(state_q);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: directed table, reset sequences and randomized instruction
// streams for mc_main_ctrl, checked against a per-instruction state plan plus
// a per-state control-word table.
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg;
  logic       irWrite, regWrite, regDst, aluSrcA, illegalOp;
  logic [1:0] aluOp, aluSrcB, pcSource;
  logic [3:0] state;

  mc_main_ctrl dut (
    .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .irWrite(irWrite), .regWrite(regWrite), .regDst(regDst),
    .aluSrcA(aluSrcA), .aluOp(aluOp), .aluSrcB(aluSrcB),
    .pcSource(pcSource), .illegalOp(illegalOp), .state(state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg;
    logic       irWrite, regWrite, regDst, aluSrcA;
    logic [1:0] aluOp, aluSrcB, pcSource;
    logic       illegalOp;
  } ctrl_t;

  ctrl_t base_tbl [16];

  // Planned cycles of the current instruction: expected state and memReady to drive.
  int   plan_s [$];
  logic plan_m [$];

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010;
  endfunction

  function automatic ctrl_t exp_ctrl(input int s, input logic mr, input logic [5:0] op);
    ctrl_t c;
    c = base_tbl[s];
    if (s == 0) begin
      c.irWrite = mr;
      c.pcWrite = mr;
    end
    if (s == 1 && !legal(op)) c.illegalOp = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t act_ctrl();
    ctrl_t c;
    c = '{pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
          regWrite, regDst, aluSrcA, aluOp, aluSrcB, pcSource, illegalOp};
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, want, $time);
    end
  endtask

  // One cycle, entered at a negedge: drive, check combinational outputs, advance.
  task automatic step(input logic mr, input logic [5:0] op, input int es, output logic [3:0] st);
    memReady = mr;
    opCode   = op;
    #1;
    st = state;
    check("state", 64'(state), 64'(es));
    check("ctrl", 64'(act_ctrl()), 64'(exp_ctrl(es, mr, op)));
    @(negedge clk);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Build the cycle plan for one instruction from its class and stall counts.
  task automatic build_plan(input logic [5:0] op, input int fs, input int ms);
    plan_s.delete();
    plan_m.delete();
    for (int i = 0; i < fs; i++) begin plan_s.push_back(0); plan_m.push_back(1'b0); end
    plan_s.push_back(0); plan_m.push_back(1'b1);
    plan_s.push_back(1); plan_m.push_back(rnd_bit());
    if (op == 6'b000000) begin
      plan_s.push_back(6); plan_m.push_back(rnd_bit());
      plan_s.push_back(7); plan_m.push_back(rnd_bit());
    end else if (op == 6'b100011) begin
      plan_s.push_back(2); plan_m.push_back(rnd_bit());
      for (int i = 0; i < ms; i++) begin plan_s.push_back(3); plan_m.push_back(1'b0); end
      plan_s.push_back(3); plan_m.push_back(1'b1);
      plan_s.push_back(4); plan_m.push_back(rnd_bit());
    end else if (op == 6'b101011) begin
      plan_s.push_back(2); plan_m.push_back(rnd_bit());
      for (int i = 0; i < ms; i++) begin plan_s.push_back(5); plan_m.push_back(1'b0); end
      plan_s.push_back(5); plan_m.push_back(1'b1);
    end else if (op == 6'b000100) begin
      plan_s.push_back(8); plan_m.push_back(rnd_bit());
    end else if (op == 6'b000010) begin
      plan_s.push_back(9); plan_m.push_back(rnd_bit());
    end
  endtask

  // Run one full instruction from FETCH; returns the observed state trace (nibble per cycle).
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                           output logic [63:0] trace);
    logic [3:0] st;
    trace = '0;
    build_plan(op, fs, ms);
    for (int i = 0; i < plan_s.size(); i++) begin
      step(plan_m[i], op, plan_s[i], st);
      trace = trace | (64'(st) << (4 * i));
    end
    #1;
    check("return_to_fetch", 64'(state), 64'd0);
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    int         fs;
    int         ms;
    logic [63:0] trace;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [63:0] tr;
    logic [3:0]  st;
    logic [5:0]  op;
    logic [5:0]  ops [5];

    for (int i = 0; i < 16; i++) base_tbl[i] = '0;
    base_tbl[0].memRead = 1'b1;  base_tbl[0].aluSrcB = 2'b01;
    base_tbl[1].aluSrcB = 2'b11;
    base_tbl[2].aluSrcA = 1'b1;  base_tbl[2].aluSrcB = 2'b10;
    base_tbl[3].memRead = 1'b1;  base_tbl[3].iorD = 1'b1;
    base_tbl[4].regWrite = 1'b1; base_tbl[4].memToReg = 1'b1;
    base_tbl[5].memWrite = 1'b1; base_tbl[5].iorD = 1'b1;
    base_tbl[6].aluSrcA = 1'b1;  base_tbl[6].aluOp = 2'b10;
    base_tbl[7].regWrite = 1'b1; base_tbl[7].regDst = 1'b1;
    base_tbl[8].aluSrcA = 1'b1;  base_tbl[8].aluOp = 2'b01;
    base_tbl[8].pcWriteCond = 1'b1; base_tbl[8].pcSource = 2'b01;
    base_tbl[9].pcWrite = 1'b1;  base_tbl[9].pcSource = 2'b10;

    // Expected state traces, nibble 0 = first cycle.
    vecs[0] = '{"rtype",       6'b000000, 0, 0, 64'h7610};
    vecs[1] = '{"lw",          6'b100011, 0, 0, 64'h43210};
    vecs[2] = '{"lw_stall2",   6'b100011, 0, 2, 64'h4333210};
    vecs[3] = '{"sw",          6'b101011, 0, 0, 64'h5210};
    vecs[4] = '{"sw_stall1",   6'b101011, 0, 1, 64'h55210};
    vecs[5] = '{"beq",         6'b000100, 0, 0, 64'h810};
    vecs[6] = '{"j",           6'b000010, 0, 0, 64'h910};
    vecs[7] = '{"illegal",     6'b111111, 0, 0, 64'h10};
    vecs[8] = '{"fetch_stall3",6'b000000, 3, 0, 64'h7610000};
    vecs[9] = '{"illegal_2a",  6'b101010, 1, 0, 64'h100};

    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010;

    // Reset held: everything quiet even though FETCH would assert memRead/irWrite/pcWrite.
    reset    = 1'b0;
    memReady = 1'b1;
    opCode   = 6'b000000;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 64'(state), 64'd0);
    check("reset_ctrl", 64'(act_ctrl()), 64'd0);
    @(negedge clk);
    check("reset_ctrl_hold", 64'(act_ctrl()), 64'd0);
    reset = 1'b1;

    // Directed table.
    foreach (vecs[v]) begin
      run_instr(vecs[v].op, vecs[v].fs, vecs[v].ms, tr);
      check({"trace_", vecs[v].name}, tr, vecs[v].trace);
    end

    // Reset asserted mid-stall in MEMWR: memWrite drops and state goes to 0 with no edge.
    step(1'b1, 6'b101011, 0, st);
    step(1'b0, 6'b101011, 1, st);
    step(1'b1, 6'b101011, 2, st);
    step(1'b0, 6'b101011, 5, st);
    memReady = 1'b0;
    #1;
    check("memwr_before_reset", 64'(memWrite), 64'd1);
    reset = 1'b0;
    #1;
    check("memwr_reset_state", 64'(state), 64'd0);
    check("memwr_reset_ctrl", 64'(act_ctrl()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("memwr_reset_held", 64'(act_ctrl()), 64'd0);
    reset = 1'b1;
    run_instr(6'b000010, 0, 0, tr);
    check("trace_after_memwr_reset", tr, 64'h910);

    // Reset asserted mid-stall in MEMRD, then a clean lw from FETCH.
    step(1'b1, 6'b100011, 0, st);
    step(1'b1, 6'b100011, 1, st);
    step(1'b1, 6'b100011, 2, st);
    step(1'b0, 6'b100011, 3, st);
    memReady = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("memrd_reset_state", 64'(state), 64'd0);
    check("memrd_reset_ctrl", 64'(act_ctrl()), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_instr(6'b100011, 1, 1, tr);
    check("trace_after_memrd_reset", tr, 64'h4332100);

    // Randomized instruction stream with random stalls and junk memReady elsewhere.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 5) == 5) op = 6'($urandom);
      else                           op = ops[$urandom_range(0, 4)];
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), tr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
